// File: rtl/m6809_reset_ctrl.sv
// Reset/halt sequencer for the 6809 core: POR, debounced button, optional watchdog.
// Define M6809_RSTCTL_WDOG_EN to build the watchdog.
module m6809_reset_ctrl #(
    parameter int STRETCH_CYCLES  = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WDOG_TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_reset_req,
    input  logic       halt_req,
    input  logic       ba,
    input  logic       bs,
    input  logic       wdog_kick,
    output logic       reset_b,
    output logic       halt_b,
    output logic       halt_ack,
    output logic [1:0] rst_cause
);

    localparam int SW = $clog2(STRETCH_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        RST_HOLD,
        RUN,
        HALT_WAIT,
        HALTED
    } state_t;

    state_t          state;
    logic [SW-1:0]   stretch;
    logic            ext_s1;
    logic            ext_s2;
    logic [DW-1:0]   deb_cnt;
    logic            ext_det;
    logic            wdog_exp;

    always_ff @(posedge clk) begin
        if (reset) begin
            ext_s1  <= 1'b0;
            ext_s2  <= 1'b0;
            deb_cnt <= '0;
        end else begin
            ext_s1 <= ext_reset_req;
            ext_s2 <= ext_s1;
            if (!ext_s2)
                deb_cnt <= '0;
            else if (deb_cnt != DW'(DEBOUNCE_CYCLES))
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Fires on the edge the count reaches the threshold, held while saturated.
    assign ext_det = ext_s2 && (deb_cnt >= DW'(DEBOUNCE_CYCLES - 1));

`ifdef M6809_RSTCTL_WDOG_EN
    localparam int WW = $clog2(WDOG_TIMEOUT);

    logic [WW-1:0] wdog_cnt;
    logic          wdog_live;

    assign wdog_live = (state == RUN) || (state == HALT_WAIT);

    always_ff @(posedge clk) begin
        if (reset || state == RST_HOLD || wdog_kick)
            wdog_cnt <= '0;
        else if (wdog_live && wdog_cnt != WW'(WDOG_TIMEOUT - 1))
            wdog_cnt <= wdog_cnt + 1'b1;
    end

    assign wdog_exp = wdog_live && !wdog_kick &&
                      (wdog_cnt == WW'(WDOG_TIMEOUT - 1));
`else
    localparam int WDOG_UNUSED = WDOG_TIMEOUT;
    logic wdog_kick_unused;

    assign wdog_kick_unused = wdog_kick;
    assign wdog_exp         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RST_HOLD;
            stretch   <= SW'(STRETCH_CYCLES - 1);
            reset_b   <= 1'b0;
            halt_b    <= 1'b1;
            halt_ack  <= 1'b0;
            rst_cause <= 2'b00;
        end else if (ext_det || wdog_exp) begin
            state     <= RST_HOLD;
            stretch   <= SW'(STRETCH_CYCLES - 1);
            reset_b   <= 1'b0;
            halt_b    <= 1'b1;
            halt_ack  <= 1'b0;
            rst_cause <= ext_det ? 2'b01 : 2'b10;
        end else begin
            unique case (state)
                RST_HOLD: begin
                    if (stretch == '0) begin
                        state   <= RUN;
                        reset_b <= 1'b1;
                    end else begin
                        stretch <= stretch - 1'b1;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT_WAIT;
                        halt_b <= 1'b0;
                    end
                end
                // A withdrawn request beats a late acknowledge.
                HALT_WAIT: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halt_b <= 1'b1;
                    end else if (ba && bs) begin
                        state    <= HALTED;
                        halt_ack <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state    <= RUN;
                        halt_b   <= 1'b1;
                        halt_ack <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m6809_reset_ctrl.sv
// Directed bench for m6809_reset_ctrl with a queued expectation scoreboard.
// Watchdog steps run only when M6809_RSTCTL_WDOG_EN is defined.
module tb_m6809_reset_ctrl;

    localparam int S = 16;
    localparam int D = 4;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       ext_reset_req;
    logic       halt_req;
    logic       ba;
    logic       bs;
    logic       wdog_kick;
    logic       reset_b;
    logic       halt_b;
    logic       halt_ack;
    logic [1:0] rst_cause;

    typedef struct {
        string      tag;
        logic [4:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    m6809_reset_ctrl #(
        .STRETCH_CYCLES (S),
        .DEBOUNCE_CYCLES(D),
        .WDOG_TIMEOUT   (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ext_reset_req(ext_reset_req),
        .halt_req     (halt_req),
        .ba           (ba),
        .bs           (bs),
        .wdog_kick    (wdog_kick),
        .reset_b      (reset_b),
        .halt_b       (halt_b),
        .halt_ack     (halt_ack),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic rb, input logic hb,
                        input logic ha, input logic [1:0] c);
        exp_t e;
        logic [4:0] obs;
        e.tag = tag;
        e.v   = {rb, hb, ha, c};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e   = sb.pop_front();
        obs = {reset_b, halt_b, halt_ack, rst_cause};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed rb/hb/ha/cause=%b expected %b",
                   e.tag, obs, e.v);
        end
    endtask

    initial begin
        reset         = 1'b1;
        ext_reset_req = 1'b0;
        halt_req      = 1'b0;
        ba            = 1'b0;
        bs            = 1'b0;
        wdog_kick     = 1'b0;

        for (int i = 0; i < 5; i++)
            step($sformatf("reset[%0d]", i), 1'b0, 1'b1, 1'b0, 2'b00);

        reset = 1'b0;
        for (int k = 1; k <= 20; k++)
            step($sformatf("por[%0d]", k), k >= S, 1'b1, 1'b0, 2'b00);

        for (int i = 0; i < 13; i++) begin
            ext_reset_req = (i < 3);
            step($sformatf("glitch[%0d]", i), 1'b1, 1'b1, 1'b0, 2'b00);
        end

        // Button high for 20 samples: falls at D+1, rises 16 past last detection.
        for (int i = 0; i < 46; i++) begin
            ext_reset_req = (i < 20);
            step($sformatf("press[%0d]", i),
                 !(i >= D + 1 && i < 21 + S), 1'b1, 1'b0,
                 (i >= D + 1) ? 2'b01 : 2'b00);
        end

        halt_req = 1'b1;
        step("halt_req", 1'b1, 1'b0, 1'b0, 2'b01);
        step("halt_wait1", 1'b1, 1'b0, 1'b0, 2'b01);
        step("halt_wait2", 1'b1, 1'b0, 1'b0, 2'b01);
        ba = 1'b1;
        bs = 1'b1;
        step("halt_ack", 1'b1, 1'b0, 1'b1, 2'b01);
        for (int i = 0; i < 3; i++)
            step($sformatf("halted[%0d]", i), 1'b1, 1'b0, 1'b1, 2'b01);
        halt_req = 1'b0;
        ba       = 1'b0;
        bs       = 1'b0;
        step("halt_release", 1'b1, 1'b1, 1'b0, 2'b01);
        step("run_idle", 1'b1, 1'b1, 1'b0, 2'b01);

        halt_req = 1'b1;
        step("mh_req", 1'b1, 1'b0, 1'b0, 2'b01);
        ba = 1'b1;
        bs = 1'b1;
        step("mh_ack", 1'b1, 1'b0, 1'b1, 2'b01);
        ba = 1'b0;
        bs = 1'b0;
        for (int i = 0; i < 28; i++) begin
            logic rb;
            logic hb;
            logic ha;
            ext_reset_req = (i < 6);
            rb = !(i >= D + 1 && i < 7 + S);
            hb = !(i < D + 1 || i >= 8 + S);
            ha = (i < D + 1);
            step($sformatf("midhalt[%0d]", i), rb, hb, ha, 2'b01);
        end
        halt_req = 1'b0;
        step("mh_release", 1'b1, 1'b1, 1'b0, 2'b01);

`ifdef M6809_RSTCTL_WDOG_EN
        reset = 1'b1;
        step("wd_reset", 1'b0, 1'b1, 1'b0, 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 100; k++)
            step($sformatf("wd_expire[%0d]", k),
                 (k >= S && k < S + T) || k >= S + T + S, 1'b1, 1'b0,
                 (k >= S + T) ? 2'b10 : 2'b00);

        // First kick lands exactly on the would-be expiry edge.
        for (int j = 0; j < 180; j++) begin
            wdog_kick = (j % 60 == 59);
            step($sformatf("wd_kick[%0d]", j), 1'b1, 1'b1, 1'b0, 2'b10);
        end
        wdog_kick = 1'b0;

        halt_req = 1'b1;
        step("wd_halt_req", 1'b1, 1'b0, 1'b0, 2'b10);
        ba = 1'b1;
        bs = 1'b1;
        for (int j = 0; j < 200; j++)
            step($sformatf("wd_halted[%0d]", j), 1'b1, 1'b0, 1'b1, 2'b10);
        halt_req = 1'b0;
        ba       = 1'b0;
        bs       = 1'b0;
        step("wd_release", 1'b1, 1'b1, 1'b0, 2'b10);
`else
        for (int j = 0; j < 5000; j++)
            step($sformatf("no_wdog[%0d]", j), 1'b1, 1'b1, 1'b0, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m6809_reset_ctrl.md
# m6809_reset_ctrl

Reset and halt sequencer for the 6809 SOC. It drives the `reset_b` and `halt_b` pins of the `m6809_integration` core from three sources: the system reset, a debounced external reset button, and an optional watchdog. It also performs the halt request/acknowledge handshake, using the core's BA/BS status pins. It sits between board-level reset sources and the CPU core, and replaces the open-coded reset pulse used in simulation.

## Interface
Parameters:
- `STRETCH_CYCLES`, default 16: number of cycles `reset_b` is held low after every reset source releases (minimum 2).
- `DEBOUNCE_CYCLES`, default 4: number of consecutive synchronized-high samples of `ext_reset_req` needed to register a button press (minimum 1).
- `WDOG_TIMEOUT`, default 1024: watchdog expiry, in cycles without a kick.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high system reset.
- `ext_reset_req`  in  1  asynchronous reset button, active-high.
- `halt_req`  in  1  level request to halt the CPU (debugger/DMA).
- `ba`  in  1  CPU bus-available status.
- `bs`  in  1  CPU bus-status.
- `wdog_kick`  in  1  single-cycle watchdog restart pulse.
- `reset_b`  out  1  CPU reset, active-low, registered.
- `halt_b`  out  1  CPU halt, active-low, registered.
- `halt_ack`  out  1  high while the CPU is confirmed halted, registered.
- `rst_cause`  out  2  cause of the most recent reset: 00 POR, 01 external, 10 watchdog.

## Operation
- The FSM has four states: RST_HOLD, RUN, HALT_WAIT, HALTED.
- While `reset` is high:
  - state = RST_HOLD
  - stretch counter = STRETCH_CYCLES-1
  - `reset_b`=0, `halt_b`=1, `halt_ack`=0, `rst_cause`=00
  - synchronizer, debounce counter and watchdog counter are all cleared.
- RST_HOLD:
  - The stretch counter decrements each cycle.
  - At 0 the next state is RUN and `reset_b` becomes 1.
  - Any new reset detection reloads the counter.
  - `halt_b` is 1 and `halt_ack` is 0.
- RUN:
  - If `halt_req` is high, go to HALT_WAIT with `halt_b`=0.
- HALT_WAIT:
  - If `ba & bs`, go to HALTED with `halt_ack`=1.
  - If `halt_req` falls, go to RUN with `halt_b`=1.
- HALTED:
  - Holds while `halt_req` is high.
  - When `halt_req` falls, go to RUN; `halt_b`=1 and `halt_ack`=0 on the same edge.
- External reset path:
  - `ext_reset_req` passes through a 2-flop synchronizer, then a saturating debounce counter.
  - The counter clears on any synchronized-low sample.
  - Detection fires when the counter reaches DEBOUNCE_CYCLES.
  - While detection is held, RST_HOLD is entered from any state, `rst_cause`=01 and the stretch counter is reloaded. The stretch therefore counts from the release of the button.
- Priority, highest first: `reset`, external detection, watchdog expiry, halt handshake.
- `rst_cause` updates only on entry to RST_HOLD; it is stable otherwise.
- Reset entry from HALT_WAIT/HALTED drives `halt_b`=1 and `halt_ack`=0 on the same edge that drives `reset_b`=0.
- If `halt_req` is high when RST_HOLD exits, the FSM enters RUN for one cycle, then HALT_WAIT.
- `ba`/`bs` are ignored outside HALT_WAIT and HALTED.

## Timing
- `reset` and the outputs: outputs take their reset values on the first edge with `reset`=1. With `reset`=0 sampled at edge 1, `reset_b` rises after edge STRETCH_CYCLES.
- Button press: `ext_reset_req` rises before edge E (first sample high). Then `reset_b`=0 after edge E+1+DEBOUNCE_CYCLES. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles has no effect.
- Halt request: `halt_req` high at edge H gives `halt_b`=0 after edge H.
- Halt acknowledge: `ba & bs` high at edge A in HALT_WAIT gives `halt_ack`=1 after edge A.
- Halt release: `halt_req` low at edge R gives `halt_b`=1 and `halt_ack`=0 after edge R.
- All counters use $clog2 widths and saturate; none wraps.

## Configuration
- `M6809_RSTCTL_WDOG_EN` defined:
  - The watchdog counter increments in RUN and HALT_WAIT, holds in HALTED, and clears in RST_HOLD or on `wdog_kick`.
  - When it reaches WDOG_TIMEOUT-1, the FSM enters RST_HOLD with `rst_cause`=10.
  - A `wdog_kick` on the expiry cycle wins: the counter clears and no reset occurs.
- `M6809_RSTCTL_WDOG_EN` undefined:
  - No watchdog logic; `wdog_kick` is ignored.
  - `rst_cause` never reports 10.

## Test plan
- POR, default parameters: `reset`=1 for 5 cycles, then 0 → `reset_b`=0 for exactly 16 cycles then 1; `halt_b`=1, `halt_ack`=0, `rst_cause`=00 throughout.
- Button glitch and press:
  - `ext_reset_req` high for 3 cycles → no reset.
  - `ext_reset_req` high for 20 cycles → `reset_b` falls 5 cycles after the first high sample, stays low until 16 cycles after the button is released; `rst_cause`=01.
- Halt handshake:
  - `halt_req`=1 → `halt_b`=0 the next cycle.
  - `ba`=`bs`=1 three cycles later → `halt_ack`=1 the following cycle.
  - Drop `halt_req` → `halt_b`=1 and `halt_ack`=0 together.
- Reset mid-halt: in HALTED, assert the button → `halt_b`=1 and `halt_ack`=0 on the same edge as `reset_b`=0; with `halt_req` still high, HALT_WAIT is re-entered one cycle after `reset_b` rises.
- Watchdog (`M6809_RSTCTL_WDOG_EN`, WDOG_TIMEOUT=64):
  - No kicks → reset after 64 RUN cycles, `rst_cause`=10.
  - Kicks every 60 cycles → no reset.
  - Halted for 200 cycles → no reset.
- Watchdog compiled out: no kicks for 5000 cycles → `reset_b` stays 1.
